spi_apb_slave: RTL

- SPI responder (mode 0, MSB first) that decodes register-map command frames from the external SPI master and issues APB3 master transfers into the register map.
- Sits between the SPI pads and the APB register map.
- All SPI inputs are oversampled in the system clock domain; there is no second clock.
- Supports single accesses and auto-incrementing bursts while cs_n stays low.

---
 rtl/spi_apb_slave.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/spi_apb_slave.sv
// spi_apb_slave: SPI mode-0 command decoder issuing APB3 transfers, SPI oversampled in clk.
// Define SPI_APB_ERR_CNT_EN to build the saturating error counter on err_cnt.
module spi_apb_slave #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16,
    parameter logic [7:0] SYNC_BYTE = 8'h17,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              frame_err,
    output logic [7:0]        err_cnt
);
    localparam int HDR_W = DATA_W + ADDR_W + 12;
    localparam int CNT_W = $clog2(HDR_W + 1);
    localparam int OUT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, HDR, CHECK, SETUP, ACCESS, WORD, DRAIN} state_t;
    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_d, cs_d, wr, inc;
    logic [HDR_W-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [OUT_W-1:0] out_cnt;
    logic [DATA_W-1:0] rd_buf, tx, word, rd_next;
    logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_fall;
    logic shifting, hdr_done, word_done, in_apb, bad_sync, overrun, apb_done;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign in_apb    = (state == SETUP) || (state == ACCESS);
    assign shifting  = ~cs_s && (in_apb || state == HDR || state == WORD);
    assign hdr_done  = (state == HDR) && shifting && sclk_rise && bit_cnt == CNT_W'(HDR_W - 1);
    assign word_done = (state != HDR) && shifting && sclk_rise && bit_cnt == CNT_W'(DATA_W - 1);
    assign bad_sync  = (state == CHECK) && shreg[ADDR_W+11:ADDR_W+4] != SYNC_BYTE;
    assign overrun   = word_done && in_apb;
    assign apb_done  = (state == ACCESS) && pready;
    assign word      = {shreg[DATA_W-2:0], mosi_s};
    // A read finishing on the same cycle as a word boundary must still reach miso.
    assign rd_next   = (apb_done && !wr) ? prdata : rd_buf;
    assign psel      = in_apb;
    assign penable   = state == ACCESS;
    assign pwrite    = wr;
    assign spi_miso  = tx[DATA_W-1];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cs_fall ? HDR : IDLE;
            HDR:     state_nx = cs_s ? IDLE : hdr_done ? CHECK : HDR;
            CHECK:   state_nx = bad_sync ? DRAIN : SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  state_nx = !pready ? ACCESS : cs_s ? IDLE : WORD;
            WORD:    state_nx = word_done ? SETUP : cs_s ? IDLE : WORD;
            DRAIN:   state_nx = cs_s ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            paddr     <= '0;
            pwdata    <= '0;
            wr        <= 1'b0;
            inc       <= 1'b0;
            rd_buf    <= '0;
            tx        <= '0;
            out_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            state     <= state_nx;
            if (cs_fall || state == CHECK) begin
                bit_cnt <= '0;
            end else if (shifting && sclk_rise) begin
                shreg   <= {shreg[HDR_W-2:0], mosi_s};
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end
            if (state == CHECK && !bad_sync) begin
                paddr <= shreg[ADDR_W-1:0];
                wr    <= shreg[ADDR_W+2];
                inc   <= shreg[ADDR_W+1];
                if (shreg[ADDR_W+2])
                    pwdata <= shreg[HDR_W-1 -: DATA_W];
            end
            if (state == WORD && word_done) begin
                if (inc)
                    paddr <= paddr + ADDR_W'(2);
                if (wr)
                    pwdata <= word;
            end
            rd_buf    <= rd_next;
            frame_err <= bad_sync || overrun || (frame_err && !cs_fall);
            if (cs_fall) begin
                tx      <= rd_buf;
                out_cnt <= '0;
            end else if (sclk_fall && !cs_s) begin
                out_cnt <= out_cnt + 1'b1;
                tx      <= out_cnt == OUT_W'(DATA_W - 1) ? rd_next : {tx[DATA_W-2:0], 1'b0};
            end
        end
    end

`ifdef SPI_APB_ERR_CNT_EN
    logic [7:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if ((bad_sync || overrun || (apb_done && pslverr)) && cnt != 8'hff)
            cnt <= cnt + 8'd1;
    end
    assign err_cnt = cnt;
`else
    assign err_cnt = '0;
`endif
endmodule
